// File: rtl/conv1d_output_packer_pkg.sv
// Shared constants and types for the conv1d output packer.
package conv1d_output_packer_pkg;

   localparam int BYTE_SIZE  = 8;
   localparam int INT32_SIZE = 32;
   localparam int LANES      = INT32_SIZE / BYTE_SIZE;
   localparam int IDX_W      = $clog2(LANES);

   // CFU command opcodes that reach this block through the response mux
   typedef enum logic [2:0] {
      CMD_POP   = 3'd1,
      CMD_COUNT = 3'd2,
      CMD_FLUSH = 3'd3,
      CMD_CLEAR = 3'd4
   } cmd_op_e;

   // One packed word: lane 0 sits in bits [7:0] (little-endian)
   typedef logic [LANES-1:0][BYTE_SIZE-1:0] word_t;

endpackage

// File: rtl/conv1d_output_packer_sync_fifo.sv
// Single-clock FIFO with registered read port, synchronous clear and
// drop/fail strobes so the owner can keep sticky error flags.
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             drop_o,
   output logic             fail_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;
   logic             rd_ok, wr_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

   // A pop only needs data present; a push into a full FIFO is legal when
   // the same cycle pops (no fall-through on an empty FIFO).
   assign rd_ok  = !clr_i && rd_en_i && !empty_o;
   assign wr_ok  = !clr_i && wr_en_i && (!full_o || rd_ok);
   assign drop_o = !clr_i && wr_en_i && !wr_ok;
   assign fail_o = !clr_i && rd_en_i && empty_o;

   // Occupancy next state
   always_comb begin
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
   end

   // Storage array; no reset needed, occupancy guards reads
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Pointers, count and registered read port; clear keeps rd_data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else if (clr_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q];
         end
         rd_valid_q <= rd_ok;
         count_q    <= count_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign count_o    = count_q;

endmodule

// File: rtl/conv1d_output_packer.sv
// Packs four int8 quant results per 32-bit word and queues the words for
// the CPU, which drains one word per read command.
module conv1d_output_packer
   import conv1d_output_packer_pkg::*;
#(
   parameter  int FIFO_DEPTH = 64,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   input  logic [INT32_SIZE-1:0] in_data_i,
   input  logic                  flush_i,
   input  logic                  rd_en_i,
   input  logic                  clear_i,
   output logic [INT32_SIZE-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic [CNT_W-1:0]      word_count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   logic [IDX_W-1:0] byte_idx_q;
   word_t            pack_reg_q, merged;
   logic             last_byte, push, drop, fail;
   logic             overflow_q, underflow_q;
   logic             unused_in_hi;

   // Quant already clamped to int8, so only the low byte carries data
   assign unused_in_hi = ^in_data_i[INT32_SIZE-1:BYTE_SIZE];

   // Lanes above byte_idx are always zero in pack_reg, so a flushed
   // partial word comes out zero-padded with no extra masking.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign merged[l] = (in_valid_i && byte_idx_q == IDX_W'(l))
                         ? in_data_i[BYTE_SIZE-1:0] : pack_reg_q[l];
   end

   assign last_byte = in_valid_i && (byte_idx_q == IDX_W'(LANES - 1));
   assign push      = !clear_i &&
                      (last_byte || (flush_i && (in_valid_i || byte_idx_q != '0)));

   sync_fifo #(.WIDTH(INT32_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clear_i),
      .wr_en_i    (push),
      .wr_data_i  (merged),
      .rd_en_i    (rd_en_i),
      .rd_data_o  (rd_data_o),
      .rd_valid_o (rd_valid_o),
      .count_o    (word_count_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .drop_o     (drop),
      .fail_o     (fail)
   );

   // Byte lane index and partial word; restart after every push, even a dropped one
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_idx_q <= '0;
         pack_reg_q <= '0;
      end else if (clear_i || push) begin
         byte_idx_q <= '0;
         pack_reg_q <= '0;
      end else if (in_valid_i) begin
         byte_idx_q <= byte_idx_q + 1'b1;
         pack_reg_q <= merged;
      end
   end

   // Sticky loss/underrun flags, cleared only by reset or clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clear_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q  | drop;
         underflow_q <= underflow_q | fail;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule

// File: tb/tb_conv1d_output_packer.sv
// Scenario bench for conv1d_output_packer with a small FIFO so that the
// full/overflow corners are cheap to reach.
module tb_conv1d_output_packer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk, rst, in_valid, flush, rd_en, clear;
   logic [31:0]   in_data, rd_data;
   logic          rd_valid, empty, full, overflow, underflow;
   logic [CW-1:0] word_count;

   int            vectors = 0;
   int            miscompares = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   exp_w, last_rd;

   conv1d_output_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .flush_i(flush), .rd_en_i(rd_en), .clear_i(clear),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .word_count_o(word_count),
      .empty_o(empty), .full_o(full), .overflow_o(overflow), .underflow_o(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given inputs, then idle; outputs settle 1 ns after the edge
   task automatic drive(input bit iv, input logic [31:0] d, input bit fl, input bit rd, input bit cl);
      in_valid = iv; in_data = d; flush = fl; rd_en = rd; clear = cl;
      @(posedge clk); #1;
      in_valid = 0; in_data = '0; flush = 0; rd_en = 0; clear = 0;
   endtask

   // Four bytes, little-endian; upper bits sign-extended like quant output
   task automatic send_word(input logic [31:0] w, input bit expect_stored);
      for (int i = 0; i < 4; i++) drive(1, {{24{w[8*i+7]}}, w[8*i +: 8]}, 0, 0, 0);
      if (expect_stored) exp_q.push_back(w);
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 0; in_data = '0; flush = 0; rd_en = 0; clear = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd got data=%h vld=%b exp 0/0", rd_data, rd_valid); end
      vectors++; if (word_count !== '0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_cnt got cnt=%0d e=%b f=%b exp 0/1/0", word_count, empty, full); end
      vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags got o=%b u=%b exp 0/0", overflow, underflow); end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_pack();
      send_word(32'h80FF0201, 1);
      vectors++; if (word_count !== CW'(1) || empty !== 1'b0) begin miscompares++; $display("FAIL pack_count got %0d exp 1", word_count); end
      drive(0, 0, 0, 1, 0);
      exp_w = exp_q.pop_front(); last_rd = exp_w;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL pack_pop got vld=%b %h exp 1 %h", rd_valid, rd_data, exp_w); end
      drive(0, 0, 0, 0, 0);
      vectors++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL pack_idle got vld=%b empty=%b exp 0/1", rd_valid, empty); end
   endtask

   task automatic test_flush();
      drive(1, 32'h11, 0, 0, 0);
      drive(1, 32'h22, 0, 0, 0);
      drive(0, 0, 1, 0, 0); exp_q.push_back(32'h00002211);
      vectors++; if (word_count !== CW'(1)) begin miscompares++; $display("FAIL flush_partial got cnt=%0d exp 1", word_count); end
      drive(0, 0, 1, 0, 0);
      vectors++; if (word_count !== CW'(1)) begin miscompares++; $display("FAIL flush_noop got cnt=%0d exp 1", word_count); end
      // flush with the third byte: one padded push
      drive(1, 32'h33, 0, 0, 0);
      drive(1, 32'h44, 0, 0, 0);
      drive(1, 32'h55, 1, 0, 0); exp_q.push_back(32'h00554433);
      // flush with the completing byte: still a single push
      drive(1, 32'h01, 0, 0, 0);
      drive(1, 32'h02, 0, 0, 0);
      drive(1, 32'h03, 0, 0, 0);
      drive(1, 32'hFFFFFF84, 1, 0, 0); exp_q.push_back(32'h84030201);
      vectors++; if (word_count !== CW'(3)) begin miscompares++; $display("FAIL flush_inval got cnt=%0d exp 3", word_count); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0);
         exp_w = exp_q.pop_front(); last_rd = exp_w;
         vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL flush_pop%0d got vld=%b %h exp 1 %h", i, rd_valid, rd_data, exp_w); end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) send_word(32'hA0B0C0D0 + 32'(i * 32'h01010101), i < DEPTH);
      vectors++; if (full !== 1'b1 || overflow !== 1'b1 || word_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL ovf_state got f=%b o=%b cnt=%0d exp 1/1/%0d", full, overflow, word_count, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0);
         exp_w = exp_q.pop_front(); last_rd = exp_w;
         vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL ovf_pop%0d got vld=%b %h exp 1 %h", i, rd_valid, rd_data, exp_w); end
      end
      vectors++; if (empty !== 1'b1 || overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_drained got e=%b o=%b exp 1/1", empty, overflow); end
      drive(0, 0, 0, 0, 1);
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", overflow); end
   endtask

   task automatic test_underflow();
      drive(0, 0, 0, 1, 0);
      vectors++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== last_rd) begin miscompares++; $display("FAIL udf got u=%b vld=%b %h exp 1/0 %h", underflow, rd_valid, rd_data, last_rd); end
      // push+pop on empty: no fall-through, word kept
      drive(1, 32'h0A, 0, 0, 0);
      drive(1, 32'h0B, 0, 0, 0);
      drive(1, 32'h0C, 0, 0, 0);
      drive(1, 32'h0D, 0, 1, 0);
      vectors++; if (rd_valid !== 1'b0 || word_count !== CW'(1) || rd_data !== last_rd) begin miscompares++; $display("FAIL udf_nofall got vld=%b cnt=%0d %h exp 0/1 %h", rd_valid, word_count, rd_data, last_rd); end
      drive(1, 32'h77, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      vectors++; if (underflow !== 1'b0 || word_count !== '0 || rd_data !== last_rd) begin miscompares++; $display("FAIL udf_clear got u=%b cnt=%0d %h exp 0/0 %h", underflow, word_count, rd_data, last_rd); end
      // clear also dropped the partial byte: next word starts at lane 0
      send_word(32'h44332211, 1);
      drive(0, 0, 0, 1, 0);
      exp_w = exp_q.pop_front(); last_rd = exp_w;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL udf_after got vld=%b %h exp 1 %h", rd_valid, rd_data, exp_w); end
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < DEPTH; i++) send_word(32'h10203040 ^ 32'(i << 4), 1);
      drive(1, 32'h5A, 0, 0, 0);
      drive(1, 32'h6B, 0, 0, 0);
      drive(1, 32'h7C, 0, 0, 0);
      drive(1, 32'h0D, 0, 1, 0); exp_q.push_back(32'h0D7C6B5A);
      exp_w = exp_q.pop_front(); last_rd = exp_w;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL fpp_pop got vld=%b %h exp 1 %h", rd_valid, rd_data, exp_w); end
      vectors++; if (overflow !== 1'b0 || word_count !== CW'(DEPTH) || full !== 1'b1) begin miscompares++; $display("FAIL fpp_state got o=%b cnt=%0d f=%b exp 0/%0d/1", overflow, word_count, full, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0);
         exp_w = exp_q.pop_front(); last_rd = exp_w;
         vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL fpp_drain%0d got vld=%b %h exp 1 %h", i, rd_valid, rd_data, exp_w); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) send_word(32'hCAFE0000 + 32'(i), 1);
      drive(1, 32'hEE, 0, 0, 0);
      drive(1, 32'hDD, 0, 0, 0);
      #2 rst = 1;
      #1;
      exp_q.delete();
      vectors++; if (rd_data !== 32'h0 || rd_valid !== 1'b0 || word_count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid got %h vld=%b cnt=%0d e=%b f=%b o=%b u=%b exp all reset", rd_data, rd_valid, word_count, empty, full, overflow, underflow);
      end
      @(posedge clk); #1 rst = 0;
      send_word(32'h04030201, 1);
      vectors++; if (word_count !== CW'(1)) begin miscompares++; $display("FAIL rst_fresh_cnt got %0d exp 1", word_count); end
      drive(0, 0, 0, 1, 0);
      exp_w = exp_q.pop_front();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin miscompares++; $display("FAIL rst_fresh got vld=%b %h exp 1 %h", rd_valid, rd_data, exp_w); end
   endtask

   initial begin
      last_rd = '0;
      test_reset();
      test_pack();
      test_flush();
      test_overflow();
      test_underflow();
      test_full_pushpop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
